data_pack: RTL and testbench
============================

DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: data_in  in  7  input symbol.
REQ-004 SHALL have ports: sop_in  in  1  symbol is the first of its packet; eop_in  in  1  symbol is the last of its packet; valid_in  in  1  input symbol valid.
REQ-005 SHALL have ports: ready_out  out  1  block accepts a symbol this cycle.
REQ-006 SHALL have ports: ready_in  in  1  downstream accepts the output word this cycle.
REQ-007 SHALL have ports: data_out  out  32  packed word; sop_out  out  1  first word of packet; eop_out  out  1  last word of packet; valid_out  out  1  output word valid.
REQ-008 SHALL have ports: nbits_out  out  6  count of valid bits in data_out, 1..32, LSB-aligned.

Function
REQ-009 Symbol accepted iff valid_in && ready_out at the rising edge; output transfer iff valid_out && ready_in.
REQ-010 Symbols SHALL be packed as a continuous LSB-first bitstream: symbol k of a packet occupies stream bits [7k+6:7k]; word n carries stream bits [32n+31:32n]; symbols may straddle words.
REQ-011 SHALL hold a 39-bit accumulator and a bit count (0..31 between words).
REQ-012 States: IDLE (no packet open), ACTIVE (packet open), FLUSH (emitting final remainder word).
REQ-013 IDLE: accepted symbol with sop_in=1 opens a packet -> ACTIVE (or completes it if eop_in=1); accepted symbol with sop_in=0 SHALL be discarded.
REQ-014 ACTIVE: accepted symbol with sop_in=1 SHALL discard residual bits and start a new packet with that symbol.
REQ-015 When an accepted symbol brings count+7 >= 32, SHALL load the low 32 bits into the output register (nbits_out=32) and retain count+7-32 bits.
REQ-016 On accepted eop symbol with count+7 < 32: emit one word, nbits_out=count+7, upper bits zero, eop_out=1 -> IDLE.
REQ-017 On eop with count+7 = 32: emit one word, nbits_out=32, eop_out=1 -> IDLE.
REQ-018 On eop with count+7 > 32: emit full word (eop_out=0), enter FLUSH, then emit remainder word, nbits_out=count+7-32, zero-padded, eop_out=1 -> IDLE.
REQ-019 sop_out=1 on the first word of each packet only; a word MAY carry sop_out and eop_out together.
REQ-020 Latency: word SHALL be valid the cycle after the edge accepting the symbol that completes it.
REQ-021 ready_out = !rst && state!=FLUSH && (!valid_out || ready_in).
REQ-022 While valid_out && !ready_in, data_out, sop_out, eop_out, nbits_out SHALL remain stable.
REQ-023 Full throughput: one symbol per cycle with ready_in held high, no bubbles except the FLUSH cycle.

Reset
REQ-024 rst SHALL immediately clear valid_out, sop_out, eop_out, data_out, nbits_out, accumulator, count; state -> IDLE; ready_out=0 while rst=1.
REQ-025 Reset mid-packet SHALL discard all partial data; first output after release reflects only new packets.

Verification
REQ-026 Single symbol 7'h55, sop_in=eop_in=1 -> one word data_out=32'h00000055, nbits_out=7, sop_out=eop_out=1.
REQ-027 Symbols 7'h01,02,03,04,7F (sop on first, eop on last) -> word0 32'hF080C101, nbits 32, sop_out=1, eop_out=0; ready_out low one cycle; word1 32'h00000007, nbits 3, eop_out=1.
REQ-028 Backpressure: ready_in=0 for 3 cycles with word pending -> data_out held, ready_out=0 those cycles, no symbol lost; transfer on ready_in=1.
REQ-029 Abort: 2 symbols, then sop_in=1 with 7'h11 and eop_in=1 -> single word 32'h00000011, nbits 7, sop_out=eop_out=1; residual never output.
REQ-030 Reset asserted with 14 bits accumulated -> outputs 0 same cycle; after release, packet of 7'h2A -> 32'h0000002A, nbits 7.
REQ-031 Back-to-back 32-symbol packets (224 bits) with ready_in=1 -> 7 words per packet, all nbits 32, last eop_out=1, no FLUSH cycle.

Source files
------------

// File: rtl/data_pack.sv
// Packs 7-bit symbols into a continuous LSB-first bitstream of 32-bit words,
// with packet framing (sop/eop), remainder flush and output backpressure.
module data_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        ready_in,
  output logic [31:0] data_out,
  output logic        sop_out,
  output logic        eop_out,
  output logic        valid_out,
  output logic [5:0]  nbits_out
);

  localparam int unsigned SYM_W  = 7;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ACC_W  = 39;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  state_t              state, state_d;
  logic [ACC_W-1:0]    acc, acc_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                first_pend, first_pend_d;
  logic [WORD_W-1:0]   data_d;
  logic                sop_d, eop_d, valid_d;
  logic [CNT_W-1:0]    nbits_d;

  logic                accept;
  logic                slot_free;
  logic                first;
  logic [ACC_W-1:0]    base_acc, sum_acc;
  logic [CNT_W-1:0]    base_cnt, sum_cnt;

  assign slot_free = !valid_out || ready_in;
  assign ready_out = !rst && (state != S_FLUSH) && slot_free;
  assign accept    = valid_in && ready_out;

  // A sop symbol always starts from an empty accumulator, dropping any residue.
  assign base_acc = sop_in ? '0 : acc;
  assign base_cnt = sop_in ? '0 : cnt;
  assign sum_acc  = base_acc | (ACC_W'(data_in) << base_cnt);
  assign sum_cnt  = base_cnt + CNT_W'(SYM_W);
  assign first    = sop_in || first_pend;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    acc_d        = acc;
    cnt_d        = cnt;
    first_pend_d = first_pend;
    data_d       = data_out;
    sop_d        = sop_out;
    eop_d        = eop_out;
    nbits_d      = nbits_out;
    valid_d      = valid_out && !ready_in;

    case (state)
      S_FLUSH: begin
        if (slot_free) begin
          data_d       = acc[WORD_W-1:0];
          nbits_d      = cnt;
          sop_d        = 1'b0;
          eop_d        = 1'b1;
          valid_d      = 1'b1;
          acc_d        = '0;
          cnt_d        = '0;
          first_pend_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        // In IDLE a symbol without sop is dropped.
        if (accept && (sop_in || state == S_ACTIVE)) begin
          if (sum_cnt >= CNT_W'(WORD_W)) begin
            data_d       = sum_acc[WORD_W-1:0];
            nbits_d      = CNT_W'(WORD_W);
            sop_d        = first;
            eop_d        = eop_in && (sum_cnt == CNT_W'(WORD_W));
            valid_d      = 1'b1;
            acc_d        = sum_acc >> WORD_W;
            cnt_d        = sum_cnt - CNT_W'(WORD_W);
            first_pend_d = 1'b0;
            if (!eop_in)                        state_d = S_ACTIVE;
            else if (sum_cnt == CNT_W'(WORD_W)) state_d = S_IDLE;
            else                                state_d = S_FLUSH;
          end else if (eop_in) begin
            data_d       = sum_acc[WORD_W-1:0];
            nbits_d      = sum_cnt;
            sop_d        = first;
            eop_d        = 1'b1;
            valid_d      = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            first_pend_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            acc_d        = sum_acc;
            cnt_d        = sum_cnt;
            first_pend_d = first;
            state_d      = S_ACTIVE;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      first_pend <= 1'b0;
      data_out   <= '0;
      sop_out    <= 1'b0;
      eop_out    <= 1'b0;
      valid_out  <= 1'b0;
      nbits_out  <= '0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      cnt        <= cnt_d;
      first_pend <= first_pend_d;
      data_out   <= data_d;
      sop_out    <= sop_d;
      eop_out    <= eop_d;
      valid_out  <= valid_d;
      nbits_out  <= nbits_d;
    end
  end

endmodule

// File: tb/tb_data_pack.sv
// Directed-vector bench for data_pack: cycle table plus backpressure, reset and
// back-to-back full-packet sequences.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  data_in;
  logic        sop_in, eop_in, valid_in, ready_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        sop_out, eop_out, valid_out;
  logic [5:0]  nbits_out;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_pack dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .valid_out (valid_out),
    .nbits_out (nbits_out)
  );

  typedef struct {
    logic        vin;
    logic        sop;
    logic        eop;
    logic [6:0]  d;
    logic        rin;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [5:0]  e_n;
    logic        e_sop;
    logic        e_eop;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [6:0] d,
                       input logic r);
    valid_in = v; sop_in = s; eop_in = e; data_in = d; ready_in = r;
  endtask

  task automatic chk_word(input string name, input logic [31:0] d, input logic [5:0] n,
                          input logic s, input logic e);
    chk({name, ".valid"}, 32'(valid_out), 32'd1);
    chk({name, ".data"},  data_out, d);
    chk({name, ".nbits"}, 32'(nbits_out), 32'(n));
    chk({name, ".sop"},   32'(sop_out), 32'(s));
    chk({name, ".eop"},   32'(eop_out), 32'(e));
  endtask

  logic [223:0] stream [2];
  int           wcnt;
  logic [6:0]   sym;

  initial begin
    // vin sop eop d rin | rdy vld data nbits sop eop
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 7'h55, 1'b1, 1'b1, 1'b1, 32'h00000055, 6'd7,  1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 7'h01, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 7'h02, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 7'h03, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 7'h04, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b1, 1'b1, 32'hF080C101, 6'd32, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 7'h11, 1'b1, 1'b0, 1'b1, 32'h00000007, 6'd3,  1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 7'h11, 1'b1, 1'b1, 1'b1, 32'h00000011, 6'd7,  1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 7'h33, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 7'h0A, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 7'h0B, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 7'h11, 1'b1, 1'b1, 1'b1, 32'h00000011, 6'd7,  1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    @(negedge clk);
    chk("reset.ready_out", 32'(ready_out), 32'd0);
    chk("reset.valid_out", 32'(valid_out), 32'd0);
    chk("reset.data_out",  data_out, 32'd0);
    chk("reset.nbits_out", 32'(nbits_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cycle table: ready_out checked mid-cycle, outputs checked after the edge.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].vin, tbl[i].sop, tbl[i].eop, tbl[i].d, tbl[i].rin);
      @(negedge clk);
      chk($sformatf("vec%0d.ready_out", i), 32'(ready_out), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      if (tbl[i].e_vld)
        chk_word($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_n, tbl[i].e_sop, tbl[i].e_eop);
      else
        chk($sformatf("vec%0d.valid", i), 32'(valid_out), 32'd0);
    end

    // Backpressure: pending word held for 3 cycles, queued symbol not lost.
    drive(1'b1, 1'b1, 1'b1, 7'h55, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 7'h2A, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.ready_out", k), 32'(ready_out), 32'd0);
      @(posedge clk); #1;
      chk_word($sformatf("bp%0d", k), 32'h00000055, 6'd7, 1'b1, 1'b1);
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("bp_release.ready_out", 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    chk_word("bp_release", 32'h0000002A, 6'd7, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    @(posedge clk); #1;
    chk("bp_drain.valid", 32'(valid_out), 32'd0);

    // Reset with 14 bits accumulated.
    drive(1'b1, 1'b1, 1'b0, 7'h01, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 7'h02, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.valid",     32'(valid_out), 32'd0);
    chk("midrst.data",      data_out, 32'd0);
    chk("midrst.nbits",     32'(nbits_out), 32'd0);
    chk("midrst.sop_eop",   32'({sop_out, eop_out}), 32'd0);
    chk("midrst.ready_out", 32'(ready_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 7'h2A, 1'b1);
    @(posedge clk); #1;
    chk_word("postrst", 32'h0000002A, 6'd7, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    @(posedge clk); #1;

    // Two back-to-back 32-symbol packets: 7 full words each, no bubbles.
    wcnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        sym = 7'((i * 37 + p * 11 + 5) % 128);
        stream[p][7*i +: 7] = sym;
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        drive(1'b1, i == 0, i == 31, stream[p][7*i +: 7], 1'b1);
        @(negedge clk);
        chk($sformatf("b2b_p%0d_s%0d.ready_out", p, i), 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        if (valid_out) begin
          if (wcnt < 14)
            chk_word($sformatf("b2b_w%0d", wcnt), stream[wcnt / 7][32*(wcnt % 7) +: 32],
                     6'd32, (wcnt % 7) == 0, (wcnt % 7) == 6);
          wcnt++;
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
    @(posedge clk); #1;
    chk("b2b.trailing_valid", 32'(valid_out), 32'd0);
    chk("b2b.word_count", 32'(wcnt), 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
